// File: rtl/issue_scoreboard_if.sv
// rtl/issue_scoreboard_if.sv - decode/writeback signal bundle for the issue scoreboard
interface issue_scoreboard_if;
    logic       rs1_en_i;
    logic [4:0] rs1_i;
    logic       rs2_en_i;
    logic [4:0] rs2_i;
    logic       issue_i;
    logic       issue_we_i;
    logic [4:0] issue_rd_i;
    logic       wb_en_i;
    logic [4:0] wb_rd_i;
    logic       flush_i;
    logic       raw_o;
    logic       full_o;
    logic       underflow_o;

    // Pipeline side: drives decode/issue/writeback, observes hazard status
    modport master (
        output rs1_en_i, rs1_i, rs2_en_i, rs2_i,
        output issue_i, issue_we_i, issue_rd_i,
        output wb_en_i, wb_rd_i, flush_i,
        input  raw_o, full_o, underflow_o
    );

    // Scoreboard side
    modport slave (
        input  rs1_en_i, rs1_i, rs2_en_i, rs2_i,
        input  issue_i, issue_we_i, issue_rd_i,
        input  wb_en_i, wb_rd_i, flush_i,
        output raw_o, full_o, underflow_o
    );
endinterface

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - GPR pending-write scoreboard with RAW/full detection; optional SCOREBOARD_BYPASS_EN
module issue_scoreboard #(
    parameter int DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    issue_scoreboard_if.slave    sb
);
    localparam int OW = $clog2(DEPTH + 1);
    localparam logic [OW-1:0] DEPTH_CNT = OW'(DEPTH);

    logic [1:0]    pend_q [32];
    logic [1:0]    pend_d [32];
    logic [OW-1:0] outstanding_q;
    logic [OW-1:0] outstanding_d;
    logic          underflow_q;
    logic          underflow_d;

    logic          retire;
    logic          wb_orphan;
    logic          issue_acc;
    logic          out_full;
    logic          reg_full;
    logic          rs1_haz;
    logic          rs2_haz;

    // Classify writeback and compute the combinational full/raw status from registered counters
    always_comb begin
        retire    = sb.wb_en_i && (sb.wb_rd_i != 5'd0) && (pend_q[sb.wb_rd_i] != 2'd0);
        wb_orphan = sb.wb_en_i && (sb.wb_rd_i != 5'd0) && (pend_q[sb.wb_rd_i] == 2'd0);

        // A retire in the same cycle frees one outstanding slot, or one count on the same register
        out_full  = (outstanding_q == DEPTH_CNT) && !retire;
        reg_full  = (sb.issue_rd_i != 5'd0) && (pend_q[sb.issue_rd_i] == 2'd3)
                    && !(retire && (sb.wb_rd_i == sb.issue_rd_i));
        issue_acc = sb.issue_i && sb.issue_we_i && (sb.issue_rd_i != 5'd0) && !(out_full || reg_full);

        rs1_haz   = sb.rs1_en_i && (sb.rs1_i != 5'd0) && (pend_q[sb.rs1_i] != 2'd0);
        rs2_haz   = sb.rs2_en_i && (sb.rs2_i != 5'd0) && (pend_q[sb.rs2_i] != 2'd0);
`ifdef SCOREBOARD_BYPASS_EN
        // The last pending write to a source is landing now, so it can be forwarded
        if (retire && (sb.wb_rd_i == sb.rs1_i) && (pend_q[sb.rs1_i] == 2'd1)) begin
            rs1_haz = 1'b0;
        end
        if (retire && (sb.wb_rd_i == sb.rs2_i) && (pend_q[sb.rs2_i] == 2'd1)) begin
            rs2_haz = 1'b0;
        end
`endif
    end

    assign sb.full_o      = out_full || reg_full;
    assign sb.raw_o       = rs1_haz || rs2_haz;
    assign sb.underflow_o = underflow_q;

    // Next-state for per-register counters, outstanding count and sticky underflow
    always_comb begin
        pend_d = pend_q;
        if (issue_acc) begin
            pend_d[sb.issue_rd_i] = pend_d[sb.issue_rd_i] + 2'd1;
        end
        if (retire) begin
            pend_d[sb.wb_rd_i] = pend_d[sb.wb_rd_i] - 2'd1;
        end

        outstanding_d = outstanding_q;
        case ({issue_acc, retire})
            2'b10:   outstanding_d = outstanding_q + OW'(1);
            2'b01:   outstanding_d = outstanding_q - OW'(1);
            default: outstanding_d = outstanding_q;
        endcase

        // Flush discards all in-flight tracking but keeps the error flag
        if (sb.flush_i) begin
            for (int i = 0; i < 32; i++) begin
                pend_d[i] = 2'd0;
            end
            outstanding_d = '0;
        end
        pend_d[0] = 2'd0;

        underflow_d = underflow_q || wb_orphan;
    end

    // State registers with synchronous reset taking priority over everything
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                pend_q[i] <= 2'd0;
            end
            outstanding_q <= '0;
            underflow_q   <= 1'b0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                pend_q[i] <= pend_d[i];
            end
            outstanding_q <= outstanding_d;
            underflow_q   <= underflow_d;
        end
    end
endmodule

// File: tb/tb_issue_scoreboard.sv
// tb/tb_issue_scoreboard.sv - self-checking bench for issue_scoreboard
module tb_issue_scoreboard;
`ifdef SCOREBOARD_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    typedef struct packed {
        logic raw;
        logic full;
        logic uf;
    } exp_t;
    exp_t exp_q[$];

    issue_scoreboard_if sb_if ();

    issue_scoreboard #(.DEPTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .sb    (sb_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle();
        sb_if.rs1_en_i   = 1'b0;
        sb_if.rs1_i      = 5'd0;
        sb_if.rs2_en_i   = 1'b0;
        sb_if.rs2_i      = 5'd0;
        sb_if.issue_i    = 1'b0;
        sb_if.issue_we_i = 1'b0;
        sb_if.issue_rd_i = 5'd0;
        sb_if.wb_en_i    = 1'b0;
        sb_if.wb_rd_i    = 5'd0;
        sb_if.flush_i    = 1'b0;
    endtask

    task automatic iss(input logic [4:0] rd);
        sb_if.issue_i    = 1'b1;
        sb_if.issue_we_i = 1'b1;
        sb_if.issue_rd_i = rd;
    endtask

    task automatic wb(input logic [4:0] rd);
        sb_if.wb_en_i = 1'b1;
        sb_if.wb_rd_i = rd;
    endtask

    task automatic src(input logic [4:0] r1, input logic [4:0] r2);
        sb_if.rs1_en_i = (r1 != 5'd0);
        sb_if.rs1_i    = r1;
        sb_if.rs2_en_i = (r2 != 5'd0);
        sb_if.rs2_i    = r2;
    endtask

    // Queue the expectation for this cycle, sample mid-cycle, then advance past the edge
    task automatic step(input string tag, input logic r, input logic f, input logic u);
        exp_t e;
        exp_q.push_back('{raw: r, full: f, uf: u});
        @(negedge clock);
        if (exp_q.size() == 0) begin
            check({tag, ".queue"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            check({tag, ".raw"},  int'(sb_if.raw_o),       int'(e.raw));
            check({tag, ".full"}, int'(sb_if.full_o),      int'(e.full));
            check({tag, ".uf"},   int'(sb_if.underflow_o), int'(e.uf));
        end
        @(posedge clock);
        #1;
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle();
        reset = 1'b1;
        @(posedge clock);
        #1;

        step("rst0", 1'b0, 1'b0, 1'b0);
        iss(5'd5); src(5'd5, 5'd0);
        step("rst_issue", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Issue during reset was dropped
        src(5'd5, 5'd0); iss(5'd5);
        step("after_rst", 1'b0, 1'b0, 1'b0);
        src(5'd5, 5'd0);
        step("raw5", 1'b1, 1'b0, 1'b0);
        src(5'd5, 5'd0); wb(5'd5);
        step("raw5_wb", !BYP, 1'b0, 1'b0);
        src(5'd5, 5'd0);
        step("raw5_clr", 1'b0, 1'b0, 1'b0);

        // x0 is never tracked
        iss(5'd0); src(5'd0, 5'd0);
        step("x0", 1'b0, 1'b0, 1'b0);

        // Outstanding limit: x0 issue did not consume a slot
        iss(5'd1);
        step("iss1", 1'b0, 1'b0, 1'b0);
        iss(5'd2); src(5'd0, 5'd1);
        step("iss2", 1'b1, 1'b0, 1'b0);
        iss(5'd3);
        step("iss3", 1'b0, 1'b0, 1'b0);
        iss(5'd4);
        step("iss4", 1'b0, 1'b0, 1'b0);
        iss(5'd6);
        step("full_out", 1'b0, 1'b1, 1'b0);
        iss(5'd6); wb(5'd2); src(5'd6, 5'd0);
        step("full_freed", 1'b0, 1'b0, 1'b0);
        src(5'd6, 5'd2);
        step("iss6_acc", 1'b1, 1'b1, 1'b0);
        sb_if.flush_i = 1'b1; iss(5'd3);
        step("flush_a", 1'b0, 1'b1, 1'b0);
        src(5'd1, 5'd4);
        step("post_flush_a", 1'b0, 1'b0, 1'b0);

        // Per-register saturation
        for (int i = 0; i < 3; i++) begin
            iss(5'd7);
            step($sformatf("iss7_%0d", i), 1'b0, 1'b0, 1'b0);
        end
        iss(5'd7); src(5'd0, 5'd7);
        step("full_reg7", 1'b1, 1'b1, 1'b0);
        iss(5'd8);
        step("iss8", 1'b0, 1'b0, 1'b0);
        wb(5'd7); src(5'd0, 5'd7);
        step("ret7_a", 1'b1, 1'b0, 1'b0);
        wb(5'd7); src(5'd0, 5'd7);
        step("ret7_b", 1'b1, 1'b0, 1'b0);
        wb(5'd7); src(5'd0, 5'd7);
        step("ret7_c", !BYP, 1'b0, 1'b0);
        src(5'd0, 5'd7);
        step("raw7_clr", 1'b0, 1'b0, 1'b0);

        // Same-register issue and retire cancel out
        iss(5'd9);
        step("iss9", 1'b0, 1'b0, 1'b0);
        iss(5'd9); wb(5'd9); src(5'd9, 5'd0);
        step("iss_ret9", !BYP, 1'b0, 1'b0);
        src(5'd9, 5'd0);
        step("raw9_hold", 1'b1, 1'b0, 1'b0);

        // Flush then stale writeback
        sb_if.flush_i = 1'b1;
        step("flush_b", 1'b0, 1'b0, 1'b0);
        iss(5'd3);
        step("iss3b", 1'b0, 1'b0, 1'b0);
        iss(5'd4);
        step("iss4b", 1'b0, 1'b0, 1'b0);
        sb_if.flush_i = 1'b1; src(5'd3, 5'd4);
        step("flush_c", 1'b1, 1'b0, 1'b0);
        src(5'd3, 5'd4); wb(5'd0);
        step("post_flush_c", 1'b0, 1'b0, 1'b0);
        wb(5'd3);
        step("stale_wb", 1'b0, 1'b0, 1'b0);
        step("uf_set", 1'b0, 1'b0, 1'b1);
        sb_if.flush_i = 1'b1;
        step("uf_flush", 1'b0, 1'b0, 1'b1);
        step("uf_hold", 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        step("uf_rst_edge", 1'b0, 1'b0, 1'b1);
        step("uf_rst_clr", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/issue_scoreboard.md
ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the maximum number of in-flight register-writing instructions (2..15).
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port rs1_en_i  input  1  decode instruction reads rs1.
REQ-005 SHALL have port rs1_i  input  5  rs1 index.
REQ-006 SHALL have port rs2_en_i  input  1  decode instruction reads rs2.
REQ-007 SHALL have port rs2_i  input  5  rs2 index.
REQ-008 SHALL have port issue_i  input  1  decode handshake fired this cycle (valid_post and ready_post both high).
REQ-009 SHALL have port issue_we_i  input  1  issued instruction writes a GPR.
REQ-010 SHALL have port issue_rd_i  input  5  issued destination index.
REQ-011 SHALL have port wb_en_i  input  1  writeback commits a GPR write this cycle.
REQ-012 SHALL have port wb_rd_i  input  5  writeback destination index.
REQ-013 SHALL have port flush_i  input  1  pipeline flush; discard all pending state.
REQ-014 SHALL have port raw_o  output  1  RAW hazard on the decode instruction; feeds the decode controller raw input.
REQ-015 SHALL have port full_o  output  1  the issue cannot be accepted (outstanding limit or per-register counter saturated).
REQ-016 SHALL have port underflow_o  output  1  sticky error flag: a writeback arrived for a register with no pending write.

Function
REQ-017 SHALL keep a 2-bit pending counter for each register x1..x31; x0 SHALL never be pending.
REQ-018 SHALL keep an outstanding counter, 0..DEPTH, of width clog2(DEPTH+1).
REQ-019 An issue SHALL be counted only when issue_i=1, issue_we_i=1, issue_rd_i!=0 and full_o=0; such an issue SHALL increment pend[rd] and outstanding by 1 on the next edge.
REQ-020 A retire SHALL be counted when wb_en_i=1 and wb_rd_i!=0 and pend[wb_rd]!=0; it SHALL decrement pend[wb_rd] and outstanding by 1.
REQ-021 When an issue and a retire target the same register in one cycle, pend[rd] SHALL be unchanged; outstanding SHALL be unchanged.
REQ-022 When an issue and a retire target different registers in one cycle, both counters SHALL update and outstanding SHALL be unchanged.
REQ-023 A writeback with wb_en_i=1, wb_rd_i!=0 and pend[wb_rd]=0 SHALL change no counter and SHALL set underflow_o on the next edge; underflow_o SHALL remain set until reset.
REQ-024 full_o SHALL be combinational: 1 iff (outstanding==DEPTH, or pend[issue_rd_i]==3 with issue_rd_i!=0) and no retire in the same cycle frees that resource.
REQ-025 raw_o SHALL be combinational: 1 iff (rs1_en_i and rs1_i!=0 and pend[rs1_i]!=0) or the same condition for rs2.
REQ-026 raw_o SHALL be evaluated against registered counters only; an issue in the current cycle SHALL affect raw_o from the next cycle.
REQ-027 flush_i=1 SHALL zero all pend counters and outstanding on the next edge, overriding a same-cycle issue or retire; underflow_o SHALL be unaffected.
REQ-028 A writeback arriving after a flush for an instruction issued before the flush SHALL be treated per REQ-023.

Reset
REQ-029 On reset=1 at a clock edge, all pend counters, outstanding and underflow_o SHALL be 0; raw_o=0 and full_o=0 SHALL follow in the same cycle.
REQ-030 Reset SHALL take priority over flush, issue and retire; reset asserted mid-operation SHALL discard all pending state.

Configuration
REQ-031 Macro SCOREBOARD_BYPASS_EN SHALL control same-cycle writeback forwarding.
REQ-032 With SCOREBOARD_BYPASS_EN defined, a source whose pend count is 1 and whose index matches wb_rd_i with a counted retire SHALL NOT raise raw_o in that cycle.
REQ-033 Without SCOREBOARD_BYPASS_EN, raw_o SHALL follow REQ-025 unchanged; the hazard clears on the cycle after the retire.

Verification
REQ-034 Reset; issue rd=5 we=1; next cycle rs1_en=1, rs1=5 -> raw_o=1; wb_rd=5 -> raw_o=0 in the cycle after the retire (bypass off) or in the same cycle (bypass on).
REQ-035 Issue rd=0 we=1, then rs1=0 -> raw_o=0 and outstanding stays 0.
REQ-036 DEPTH=4; four issues to x1..x4 with no writeback -> full_o=1; wb_rd=2 in the same cycle as a fifth issue -> full_o=0 and the issue is accepted.
REQ-037 Three issues to rd=7 -> pend[7]=3 and full_o=1 for rd=7; an issue to rd=8 -> full_o=0; three retires of rd=7 -> raw_o on rs2=7 clears only after the third retire.
REQ-038 Same-cycle issue rd=9 and wb_rd=9 with pend[9]=1 -> pend[9] stays 1 and raw_o stays 1 for rs1=9.
REQ-039 Issue to x3 and x4, then flush_i=1 -> raw_o=0 for rs1=3 and rs2=4; a later wb_rd=3 -> underflow_o=1, held until reset.
